// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM cell and its upstream sequencer.
package lstm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } lstm_seq_state_t;

   // Cell pipeline latency, from x_in_valid to valid.
   localparam int LSTM_DLY = 6;

   // 1.0 in Q8.8.
   localparam int FRAC_ONE = 256;

   localparam int ERR_TIMEOUT  = 0;
   localparam int ERR_SPURIOUS = 1;

endpackage

// File: rtl/lstm_sequencer.sv
// Feeds a last-delimited Q8.8 sample stream into the lstm cell one step at a
// time and holds each result in a one-entry valid/ready output register.
module lstm_sequencer
   import lstm_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_x,
   input  logic             s_valid,
   input  logic             s_last,
   output logic             s_ready,
   input  logic [WIDTH-1:0] h_init,
   input  logic [WIDTH-1:0] C_init,
   input  logic             cell_ready,
   output logic [WIDTH-1:0] cell_x,
   output logic             cell_x_valid,
   output logic [WIDTH-1:0] cell_h,
   output logic             cell_h_valid,
   output logic [WIDTH-1:0] cell_C,
   output logic             cell_C_valid,
   input  logic [WIDTH-1:0] cell_y,
   input  logic [WIDTH-1:0] cell_C_out,
   input  logic             cell_valid,
   output logic [WIDTH-1:0] m_y,
   output logic [WIDTH-1:0] m_C,
   output logic [CNT_W-1:0] m_step,
   output logic             m_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [1:0]       err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   lstm_seq_state_t state, state_nxt;
   logic             first;
   logic [CNT_W-1:0] step;
   logic             last_q;
   logic [WD_W-1:0]  wdog;
   logic             accept, fire, capture, timeout;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      accept    = 1'b0;
      fire      = 1'b0;
      capture   = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            s_ready = 1'b1;
            accept  = s_valid;
            if (s_valid) state_nxt = ISSUE;
         end
         ISSUE: begin
            // Holding off while m_valid is set guarantees the result has a home.
            fire = cell_ready & ~m_valid;
            if (fire) state_nxt = WAIT;
         end
         WAIT: begin
            if (cell_valid) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end else if (wdog == WD_W'(TIMEOUT - 1)) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign cell_x_valid = fire;
   assign cell_h_valid = fire & first;
   assign cell_C_valid = fire & first;

   // NOTE: state elements use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first   <= 1'b1;
         step    <= '0;
         last_q  <= 1'b0;
         wdog    <= '0;
         cell_x  <= '0;
         cell_h  <= '0;
         cell_C  <= '0;
         m_y     <= '0;
         m_C     <= '0;
         m_step  <= '0;
         m_last  <= 1'b0;
         m_valid <= 1'b0;
         err     <= '0;
      end else begin
         if (accept) begin
            cell_x <= s_x;
            last_q <= s_last;
            if (first) begin
               cell_h <= h_init;
               cell_C <= C_init;
            end
         end

         if (fire)               wdog <= '0;
         else if (state == WAIT) wdog <= wdog + 1'b1;

         if (capture) begin
            m_y     <= cell_y;
            m_C     <= cell_C_out;
            m_step  <= step;
            m_last  <= last_q;
            m_valid <= 1'b1;
            first   <= last_q;
            step    <= last_q ? '0 : step + 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end

         // A timed-out step is dropped and the sequence abandoned.
         if (timeout) begin
            err[ERR_TIMEOUT] <= 1'b1;
            first            <= 1'b1;
            step             <= '0;
         end

         if (cell_valid && state != WAIT) err[ERR_SPURIOUS] <= 1'b1;
      end
   end

endmodule
